// File: rtl/prt_riscv_cpu_wb.sv
// Write-back stage: retires execute results, waits for load data, extracts and extends load lanes.
// Optional load timeout is enabled with `define PRT_RISCV_WB_TMO_EN.
module prt_riscv_cpu_wb #(
  parameter int P_IDX = 4,
  parameter int P_TMO = 255
) (
  input  logic             CLK_IN,
  input  logic             RST_IN,
  input  logic             EXE_VLD_IN,
  output logic             EXE_RDY_OUT,
  input  logic [P_IDX-1:0] EXE_RD_IDX_IN,
  input  logic [31:0]      EXE_DAT_IN,
  input  logic             EXE_LD_IN,
  input  logic [2:0]       EXE_LD_FMT_IN,
  input  logic [1:0]       EXE_LD_OFS_IN,
  input  logic [31:0]      MEM_DAT_IN,
  input  logic             MEM_VLD_IN,
  output logic [P_IDX-1:0] RD_IDX_OUT,
  output logic [31:0]      RD_DAT_OUT,
  output logic             RD_WR_OUT,
  output logic             LD_PEND_OUT,
  output logic [P_IDX-1:0] LD_IDX_OUT,
  input  logic             ERR_CLR_IN,
  output logic [1:0]       ERR_OUT
);

  localparam logic S_IDLE      = 1'b0;
  localparam logic S_LOAD_WAIT = 1'b1;

  logic        state;
  logic [2:0]  ld_fmt;
  logic [1:0]  ld_ofs;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic        accept;
  logic        unexp_vld;
  logic        tmo_hit;

  assign EXE_RDY_OUT = (state == S_IDLE);
  assign accept      = EXE_VLD_IN & EXE_RDY_OUT;
  assign unexp_vld   = MEM_VLD_IN & (state == S_IDLE);

`ifdef PRT_RISCV_WB_TMO_EN
  logic [15:0] wait_cnt;

  // Fires in the cycle where the counter would step onto P_TMO; a response in that cycle wins.
  assign tmo_hit = (state == S_LOAD_WAIT) && !MEM_VLD_IN &&
                   (({1'b0, wait_cnt} + 17'd1) == 17'(P_TMO));

  always_ff @(posedge CLK_IN) begin
    if (RST_IN)
      wait_cnt <= '0;
    else if (accept && EXE_LD_IN)
      wait_cnt <= '0;
    else if (state == S_LOAD_WAIT)
      wait_cnt <= wait_cnt + 16'd1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (P_TMO != 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    ld_byte = MEM_DAT_IN[7:0];
    case (ld_ofs)
      2'd1:    ld_byte = MEM_DAT_IN[15:8];
      2'd2:    ld_byte = MEM_DAT_IN[23:16];
      2'd3:    ld_byte = MEM_DAT_IN[31:24];
      default: ld_byte = MEM_DAT_IN[7:0];
    endcase
    ld_half = ld_ofs[1] ? MEM_DAT_IN[31:16] : MEM_DAT_IN[15:0];
    // Reserved funct3 encodings fall through to a full word.
    case (ld_fmt)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = MEM_DAT_IN;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state       <= S_IDLE;
      ld_fmt      <= 3'd0;
      ld_ofs      <= 2'd0;
      RD_IDX_OUT  <= '0;
      RD_DAT_OUT  <= 32'd0;
      RD_WR_OUT   <= 1'b0;
      LD_PEND_OUT <= 1'b0;
      LD_IDX_OUT  <= '0;
      ERR_OUT     <= 2'b00;
    end else begin
      RD_WR_OUT  <= 1'b0;
      ERR_OUT[0] <= unexp_vld | (ERR_OUT[0] & ~ERR_CLR_IN);
      ERR_OUT[1] <= tmo_hit   | (ERR_OUT[1] & ~ERR_CLR_IN);
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (EXE_LD_IN) begin
              ld_fmt      <= EXE_LD_FMT_IN;
              ld_ofs      <= EXE_LD_OFS_IN;
              LD_IDX_OUT  <= EXE_RD_IDX_IN;
              LD_PEND_OUT <= 1'b1;
              state       <= S_LOAD_WAIT;
            end else begin
              RD_IDX_OUT <= EXE_RD_IDX_IN;
              RD_DAT_OUT <= EXE_DAT_IN;
              RD_WR_OUT  <= (EXE_RD_IDX_IN != '0);
            end
          end
        end
        S_LOAD_WAIT: begin
          if (MEM_VLD_IN) begin
            RD_IDX_OUT  <= LD_IDX_OUT;
            RD_DAT_OUT  <= ld_val;
            RD_WR_OUT   <= (LD_IDX_OUT != '0);
            LD_PEND_OUT <= 1'b0;
            state       <= S_IDLE;
          end else if (tmo_hit) begin
            LD_PEND_OUT <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prt_riscv_cpu_wb.sv
// Directed bench for prt_riscv_cpu_wb; timeout cases are covered when PRT_RISCV_WB_TMO_EN is defined.
module tb_prt_riscv_cpu_wb;

  localparam int P_IDX = 4;
  localparam int P_TMO = 8;

  logic             CLK_IN = 1'b0;
  logic             RST_IN;
  logic             EXE_VLD_IN;
  logic             EXE_RDY_OUT;
  logic [P_IDX-1:0] EXE_RD_IDX_IN;
  logic [31:0]      EXE_DAT_IN;
  logic             EXE_LD_IN;
  logic [2:0]       EXE_LD_FMT_IN;
  logic [1:0]       EXE_LD_OFS_IN;
  logic [31:0]      MEM_DAT_IN;
  logic             MEM_VLD_IN;
  logic [P_IDX-1:0] RD_IDX_OUT;
  logic [31:0]      RD_DAT_OUT;
  logic             RD_WR_OUT;
  logic             LD_PEND_OUT;
  logic [P_IDX-1:0] LD_IDX_OUT;
  logic             ERR_CLR_IN;
  logic [1:0]       ERR_OUT;

  int errorCount = 0;
  int checkCount = 0;

  prt_riscv_cpu_wb #(.P_IDX(P_IDX), .P_TMO(P_TMO)) dut (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN),
    .EXE_VLD_IN(EXE_VLD_IN), .EXE_RDY_OUT(EXE_RDY_OUT),
    .EXE_RD_IDX_IN(EXE_RD_IDX_IN), .EXE_DAT_IN(EXE_DAT_IN),
    .EXE_LD_IN(EXE_LD_IN), .EXE_LD_FMT_IN(EXE_LD_FMT_IN), .EXE_LD_OFS_IN(EXE_LD_OFS_IN),
    .MEM_DAT_IN(MEM_DAT_IN), .MEM_VLD_IN(MEM_VLD_IN),
    .RD_IDX_OUT(RD_IDX_OUT), .RD_DAT_OUT(RD_DAT_OUT), .RD_WR_OUT(RD_WR_OUT),
    .LD_PEND_OUT(LD_PEND_OUT), .LD_IDX_OUT(LD_IDX_OUT),
    .ERR_CLR_IN(ERR_CLR_IN), .ERR_OUT(ERR_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled at that same point.
  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic applyStimulus(input logic vld, input logic [P_IDX-1:0] idx, input logic [31:0] dat,
                               input logic ld, input logic [2:0] fmt, input logic [1:0] ofs);
    EXE_VLD_IN    = vld;
    EXE_RD_IDX_IN = idx;
    EXE_DAT_IN    = dat;
    EXE_LD_IN     = ld;
    EXE_LD_FMT_IN = fmt;
    EXE_LD_OFS_IN = ofs;
  endtask

  task automatic doLoad(input string tag, input logic [P_IDX-1:0] idx, input logic [2:0] fmt,
                        input logic [1:0] ofs, input logic [31:0] mem, input logic [31:0] exp);
    applyStimulus(1'b1, idx, 32'hCAFE_0000, 1'b1, fmt, ofs);
    tick();
    applyStimulus(1'b0, '0, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput({tag, "_pend"}, {31'd0, LD_PEND_OUT}, 32'd1);
    MEM_DAT_IN = mem;
    MEM_VLD_IN = 1'b1;
    tick();
    MEM_VLD_IN = 1'b0;
    checkOutput({tag, "_wr"}, {31'd0, RD_WR_OUT}, 32'd1);
    checkOutput({tag, "_dat"}, RD_DAT_OUT, exp);
  endtask

  initial begin
    RST_IN = 1'b1;
    MEM_DAT_IN = 32'd0;
    MEM_VLD_IN = 1'b0;
    ERR_CLR_IN = 1'b0;
    applyStimulus(1'b0, '0, 32'd0, 1'b0, 3'd0, 2'd0);
    tick();
    tick();
    RST_IN = 1'b0;
    checkOutput("rst_wr",   {31'd0, RD_WR_OUT},   32'd0);
    checkOutput("rst_idx",  {28'd0, RD_IDX_OUT},  32'd0);
    checkOutput("rst_dat",  RD_DAT_OUT,           32'd0);
    checkOutput("rst_pend", {31'd0, LD_PEND_OUT}, 32'd0);
    checkOutput("rst_ldix", {28'd0, LD_IDX_OUT},  32'd0);
    checkOutput("rst_err",  {30'd0, ERR_OUT},     32'd0);
    checkOutput("rst_rdy",  {31'd0, EXE_RDY_OUT}, 32'd1);

    // Back-to-back non-loads
    applyStimulus(1'b1, 4'd3, 32'h11, 1'b0, 3'd0, 2'd0);
    tick();
    checkOutput("nl3_wr",  {31'd0, RD_WR_OUT}, 32'd1);
    checkOutput("nl3_idx", {28'd0, RD_IDX_OUT}, 32'd3);
    checkOutput("nl3_dat", RD_DAT_OUT, 32'h11);
    checkOutput("nl3_rdy", {31'd0, EXE_RDY_OUT}, 32'd1);
    applyStimulus(1'b1, 4'd4, 32'h22, 1'b0, 3'd0, 2'd0);
    tick();
    checkOutput("nl4_wr",  {31'd0, RD_WR_OUT}, 32'd1);
    checkOutput("nl4_idx", {28'd0, RD_IDX_OUT}, 32'd4);
    checkOutput("nl4_dat", RD_DAT_OUT, 32'h22);
    checkOutput("nl4_rdy", {31'd0, EXE_RDY_OUT}, 32'd1);
    applyStimulus(1'b1, 4'd5, 32'h33, 1'b0, 3'd0, 2'd0);
    tick();
    checkOutput("nl5_wr",  {31'd0, RD_WR_OUT}, 32'd1);
    checkOutput("nl5_idx", {28'd0, RD_IDX_OUT}, 32'd5);
    checkOutput("nl5_dat", RD_DAT_OUT, 32'h33);
    applyStimulus(1'b0, '0, 32'd0, 1'b0, 3'd0, 2'd0);
    tick();
    checkOutput("nl_idle_wr", {31'd0, RD_WR_OUT}, 32'd0);

    // Lane extraction and extension
    doLoad("lb2",  4'd8, 3'b000, 2'd2, 32'h1280_3456, 32'hFFFF_FF80);
    doLoad("lbu2", 4'd8, 3'b100, 2'd2, 32'h1280_3456, 32'h0000_0080);
    doLoad("lhu2", 4'd8, 3'b101, 2'd2, 32'h1280_3456, 32'h0000_1280);
    doLoad("lh3",  4'd8, 3'b001, 2'd3, 32'h1280_3456, 32'h0000_1280);
    doLoad("lh0",  4'd8, 3'b001, 2'd0, 32'h1234_8001, 32'hFFFF_8001);
    doLoad("lb1",  4'd8, 3'b000, 2'd1, 32'h1280_3456, 32'h0000_0034);
    doLoad("lbu3", 4'd8, 3'b100, 2'd3, 32'hF280_3456, 32'h0000_00F2);
    doLoad("lw1",  4'd8, 3'b010, 2'd1, 32'h1280_3456, 32'h1280_3456);
    doLoad("f011", 4'd8, 3'b011, 2'd2, 32'h8765_4321, 32'h8765_4321);
    doLoad("f111", 4'd8, 3'b111, 2'd3, 32'h8765_4321, 32'h8765_4321);
    checkOutput("lw_idx", {28'd0, RD_IDX_OUT}, 32'd8);

    // Load to x7 answered 5 cycles later, with a non-load held by execute meanwhile
    applyStimulus(1'b1, 4'd7, 32'd0, 1'b1, 3'b010, 2'd0);
    tick();
    applyStimulus(1'b1, 4'd9, 32'h99, 1'b0, 3'd0, 2'd0);
    MEM_DAT_IN = 32'hA5A5_0007;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("x7_pend%0d", i), {31'd0, LD_PEND_OUT}, 32'd1);
      checkOutput($sformatf("x7_ldix%0d", i), {28'd0, LD_IDX_OUT}, 32'd7);
      checkOutput($sformatf("x7_rdy%0d", i),  {31'd0, EXE_RDY_OUT}, 32'd0);
      checkOutput($sformatf("x7_wr%0d", i),   {31'd0, RD_WR_OUT}, 32'd0);
      if (i == 4) MEM_VLD_IN = 1'b1;
      tick();
    end
    MEM_VLD_IN = 1'b0;
    checkOutput("x7_wr",   {31'd0, RD_WR_OUT}, 32'd1);
    checkOutput("x7_idx",  {28'd0, RD_IDX_OUT}, 32'd7);
    checkOutput("x7_dat",  RD_DAT_OUT, 32'hA5A5_0007);
    checkOutput("x7_pend", {31'd0, LD_PEND_OUT}, 32'd0);
    checkOutput("x7_rdy",  {31'd0, EXE_RDY_OUT}, 32'd1);
    tick();
    applyStimulus(1'b0, '0, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput("x9_wr",  {31'd0, RD_WR_OUT}, 32'd1);
    checkOutput("x9_idx", {28'd0, RD_IDX_OUT}, 32'd9);
    checkOutput("x9_dat", RD_DAT_OUT, 32'h99);

    // Write to x0 is suppressed but data still updates
    applyStimulus(1'b1, 4'd0, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0);
    tick();
    applyStimulus(1'b0, '0, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput("x0_wr",  {31'd0, RD_WR_OUT}, 32'd0);
    checkOutput("x0_dat", RD_DAT_OUT, 32'hDEAD_BEEF);

    // Unexpected read data and sticky error handling
    MEM_VLD_IN = 1'b1;
    tick();
    MEM_VLD_IN = 1'b0;
    checkOutput("unexp_err", {30'd0, ERR_OUT}, 32'd1);
    checkOutput("unexp_wr",  {31'd0, RD_WR_OUT}, 32'd0);
    tick();
    checkOutput("sticky_err", {30'd0, ERR_OUT}, 32'd1);
    ERR_CLR_IN = 1'b1;
    tick();
    checkOutput("clr_err", {30'd0, ERR_OUT}, 32'd0);
    MEM_VLD_IN = 1'b1;
    tick();
    MEM_VLD_IN = 1'b0;
    ERR_CLR_IN = 1'b0;
    checkOutput("setwins_err", {30'd0, ERR_OUT}, 32'd1);
    ERR_CLR_IN = 1'b1;
    tick();
    ERR_CLR_IN = 1'b0;

    // Read data in the handshake cycle, then reset abandons the load
    applyStimulus(1'b1, 4'd6, 32'd0, 1'b1, 3'b010, 2'd0);
    MEM_VLD_IN = 1'b1;
    tick();
    MEM_VLD_IN = 1'b0;
    applyStimulus(1'b0, '0, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput("hs_err",  {30'd0, ERR_OUT}, 32'd1);
    checkOutput("hs_pend", {31'd0, LD_PEND_OUT}, 32'd1);
    checkOutput("hs_wr",   {31'd0, RD_WR_OUT}, 32'd0);
    RST_IN = 1'b1;
    tick();
    RST_IN = 1'b0;
    checkOutput("rstw_pend", {31'd0, LD_PEND_OUT}, 32'd0);
    checkOutput("rstw_rdy",  {31'd0, EXE_RDY_OUT}, 32'd1);
    checkOutput("rstw_err",  {30'd0, ERR_OUT}, 32'd0);
    MEM_VLD_IN = 1'b1;
    tick();
    MEM_VLD_IN = 1'b0;
    checkOutput("late_err", {30'd0, ERR_OUT}, 32'd1);
    checkOutput("late_wr",  {31'd0, RD_WR_OUT}, 32'd0);
    ERR_CLR_IN = 1'b1;
    tick();
    ERR_CLR_IN = 1'b0;

`ifdef PRT_RISCV_WB_TMO_EN
    // Load with no response times out after P_TMO wait cycles
    applyStimulus(1'b1, 4'd6, 32'd0, 1'b1, 3'b010, 2'd0);
    tick();
    applyStimulus(1'b0, '0, 32'd0, 1'b0, 3'd0, 2'd0);
    for (int i = 0; i < P_TMO; i++) begin
      checkOutput($sformatf("tmo_pend%0d", i), {31'd0, LD_PEND_OUT}, 32'd1);
      tick();
    end
    checkOutput("tmo_err",  {30'd0, ERR_OUT}, 32'd2);
    checkOutput("tmo_pend", {31'd0, LD_PEND_OUT}, 32'd0);
    checkOutput("tmo_rdy",  {31'd0, EXE_RDY_OUT}, 32'd1);
    checkOutput("tmo_wr",   {31'd0, RD_WR_OUT}, 32'd0);
    ERR_CLR_IN = 1'b1;
    tick();
    ERR_CLR_IN = 1'b0;
    checkOutput("tmo_clr", {30'd0, ERR_OUT}, 32'd0);

    // Response arriving in the timeout cycle wins
    applyStimulus(1'b1, 4'd6, 32'd0, 1'b1, 3'b010, 2'd0);
    tick();
    applyStimulus(1'b0, '0, 32'd0, 1'b0, 3'd0, 2'd0);
    MEM_DAT_IN = 32'h0BAD_F00D;
    for (int i = 0; i < P_TMO; i++) begin
      if (i == P_TMO - 1) MEM_VLD_IN = 1'b1;
      tick();
    end
    MEM_VLD_IN = 1'b0;
    checkOutput("tmoe_wr",  {31'd0, RD_WR_OUT}, 32'd1);
    checkOutput("tmoe_dat", RD_DAT_OUT, 32'h0BAD_F00D);
    checkOutput("tmoe_err", {30'd0, ERR_OUT}, 32'd0);
`else
    // Without the timeout a load waits indefinitely
    applyStimulus(1'b1, 4'd6, 32'd0, 1'b1, 3'b010, 2'd0);
    tick();
    applyStimulus(1'b0, '0, 32'd0, 1'b0, 3'd0, 2'd0);
    for (int i = 0; i < 3 * P_TMO; i++) tick();
    checkOutput("notmo_pend", {31'd0, LD_PEND_OUT}, 32'd1);
    checkOutput("notmo_err",  {30'd0, ERR_OUT}, 32'd0);
    checkOutput("notmo_rdy",  {31'd0, EXE_RDY_OUT}, 32'd0);
    MEM_DAT_IN = 32'h0BAD_F00D;
    MEM_VLD_IN = 1'b1;
    tick();
    MEM_VLD_IN = 1'b0;
    checkOutput("notmo_wr",  {31'd0, RD_WR_OUT}, 32'd1);
    checkOutput("notmo_dat", RD_DAT_OUT, 32'h0BAD_F00D);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
